iram_write_ctl: RTL

IRAM_WRITE_CTL -- requirements
Module: iram_write_ctl

---
 rtl/iram_write_ctl_if.sv | 36 +++
 rtl/iram_write_ctl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/iram_write_ctl_if.sv
// Bus bundle between the IRAM write controller and its CPU/debug/IRAM neighbours.
// The slave view is the controller, the master view is whoever drives the requests.
interface iram_write_ctl_if #(
  parameter int AW = 14,
  parameter int DW = 48,
  parameter int BW = 16
);
  logic          state_write;
  logic          iwrited;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          idebug;
  logic          promdisabled;
  logic          dbg_valid;
  logic          dbg_ready;
  logic [AW-1:0] dbg_addr;
  logic [BW-1:0] dbg_data;
  logic          iwe;
  logic [AW-1:0] iram_addr;
  logic [DW-1:0] iram_wdata;
  logic          ramdisable;
  logic          busy;
  logic          dbg_done;

  modport slave (
    input  state_write, iwrited, cpu_addr, cpu_data, idebug, promdisabled,
           dbg_valid, dbg_addr, dbg_data,
    output dbg_ready, iwe, iram_addr, iram_wdata, ramdisable, busy, dbg_done
  );

  modport master (
    output state_write, iwrited, cpu_addr, cpu_data, idebug, promdisabled,
           dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready, iwe, iram_addr, iram_wdata, ramdisable, busy, dbg_done
  );
endinterface

// File: rtl/iram_write_ctl.sv
// IRAM write controller: arbitrates a one-entry CPU write buffer against a debug
// word assembled from BW-wide chunks, and holds iwe for WR_HOLD cycles per write.
module iram_write_ctl #(
  parameter int AW      = 14,
  parameter int DW      = 48,
  parameter int BW      = 16,
  parameter int WR_HOLD = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  iram_write_ctl_if.slave io_bus
);

  localparam int NCH = DW / BW;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);
  localparam logic [2:0]    HOLD_INIT  = 3'(WR_HOLD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

  state_t        r_state,    w_state_n;
  logic [CW-1:0] r_cnt,      w_cnt_n;
  logic [DW-1:0] r_stage,    w_stage_n;
  logic [AW-1:0] r_dbg_addr, w_dbg_addr_n;
  logic          r_dbg_full, w_dbg_full_n;
  logic          r_cpu_pend, w_cpu_pend_n;
  logic [AW-1:0] r_cpu_addr, w_cpu_addr_n;
  logic [DW-1:0] r_cpu_data, w_cpu_data_n;
  logic          r_iwe,      w_iwe_n;
  logic [AW-1:0] r_addr,     w_addr_n;
  logic [DW-1:0] r_wdata,    w_wdata_n;
  logic [2:0]    r_hold,     w_hold_n;
  logic          r_src_dbg,  w_src_dbg_n;
  logic          r_done,     w_done_n;
  logic          r_busy,     w_busy_n;

  logic w_cpu_req;
  logic w_ready;
  logic w_acc;

  assign w_cpu_req = io_bus.state_write & io_bus.iwrited;
  assign w_ready   = (r_state != WRITE) & ~r_dbg_full;
  assign w_acc     = io_bus.dbg_valid & w_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_dbg_addr <= '0;
      r_dbg_full <= 1'b0;
      r_cpu_pend <= 1'b0;
      r_cpu_addr <= '0;
      r_cpu_data <= '0;
      r_iwe      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_hold     <= '0;
      r_src_dbg  <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_stage    <= w_stage_n;
      r_dbg_addr <= w_dbg_addr_n;
      r_dbg_full <= w_dbg_full_n;
      r_cpu_pend <= w_cpu_pend_n;
      r_cpu_addr <= w_cpu_addr_n;
      r_cpu_data <= w_cpu_data_n;
      r_iwe      <= w_iwe_n;
      r_addr     <= w_addr_n;
      r_wdata    <= w_wdata_n;
      r_hold     <= w_hold_n;
      r_src_dbg  <= w_src_dbg_n;
      r_done     <= w_done_n;
      r_busy     <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_stage_n    = r_stage;
    w_dbg_addr_n = r_dbg_addr;
    w_dbg_full_n = r_dbg_full;
    w_cpu_pend_n = r_cpu_pend;
    w_cpu_addr_n = r_cpu_addr;
    w_cpu_data_n = r_cpu_data;
    w_iwe_n      = r_iwe;
    w_addr_n     = r_addr;
    w_wdata_n    = r_wdata;
    w_hold_n     = r_hold;
    w_src_dbg_n  = r_src_dbg;
    w_done_n     = 1'b0;

    case (r_state)
      IDLE, LOAD: begin
        if ((r_state == LOAD) && !io_bus.idebug && !r_dbg_full) begin
          w_cnt_n   = '0;
          w_state_n = IDLE;
        end else if (w_acc) begin
          for (int k = 0; k < NCH; k++) begin
            if (r_cnt == CW'(k)) w_stage_n[k*BW +: BW] = io_bus.dbg_data;
          end
          if (r_cnt == '0) w_dbg_addr_n = io_bus.dbg_addr;
          if (r_cnt == LAST_CHUNK) begin
            w_cnt_n      = '0;
            w_dbg_full_n = 1'b1;
          end else begin
            w_cnt_n   = r_cnt + 1'b1;
            w_state_n = LOAD;
          end
        end

        // A debug word only competes once its full flag is registered, so a CPU
        // request arriving with the last chunk always wins the first slot.
        if (w_cpu_req || r_cpu_pend) begin
          w_addr_n     = w_cpu_req ? io_bus.cpu_addr : r_cpu_addr;
          w_wdata_n    = w_cpu_req ? io_bus.cpu_data : r_cpu_data;
          w_cpu_pend_n = 1'b0;
          w_iwe_n      = 1'b1;
          w_hold_n     = HOLD_INIT;
          w_src_dbg_n  = 1'b0;
          w_state_n    = WRITE;
        end else if (r_dbg_full) begin
          w_addr_n    = r_dbg_addr;
          w_wdata_n   = r_stage;
          w_iwe_n     = 1'b1;
          w_hold_n    = HOLD_INIT;
          w_src_dbg_n = 1'b1;
          w_state_n   = WRITE;
        end
      end

      WRITE: begin
        if (w_cpu_req) begin
          w_cpu_addr_n = io_bus.cpu_addr;
          w_cpu_data_n = io_bus.cpu_data;
          w_cpu_pend_n = 1'b1;
        end
        // Leaving through IDLE/LOAD gives the mandatory iwe=0 gap before any
        // pending source is written.
        if (r_hold == '0) begin
          w_iwe_n = 1'b0;
          if (r_src_dbg) begin
            w_done_n     = 1'b1;
            w_dbg_full_n = 1'b0;
          end
          w_state_n = ((r_cnt != '0) || w_dbg_full_n) ? LOAD : IDLE;
        end else begin
          w_hold_n = r_hold - 1'b1;
        end
      end

      default: w_state_n = IDLE;
    endcase

    w_busy_n = w_cpu_pend_n | w_dbg_full_n | (w_state_n != IDLE);
  end

  assign io_bus.dbg_ready  = w_ready;
  assign io_bus.iwe        = r_iwe;
  assign io_bus.iram_addr  = r_addr;
  assign io_bus.iram_wdata = r_wdata;
  assign io_bus.busy       = r_busy;
  assign io_bus.dbg_done   = r_done;
  assign io_bus.ramdisable = r_iwe | io_bus.idebug
                           | ~(io_bus.promdisabled | io_bus.iwrited);

endmodule
